// File: rtl/bfloat_mul_pipe.sv
// Three-stage BFloat16 multiplier (unpack / multiply / normalize-round-pack) with
// valid/ready on both sides; the whole pipe freezes while the output is back-pressured.
module bfloat_mul_pipe #(
    parameter int          FTZ  = 1,
    parameter logic [15:0] QNAN = 16'h7FC0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic        ovf,
    output logic        unf,
    output logic        inv
);

    typedef enum logic [1:0] {SP_NONE, SP_ZERO, SP_INF, SP_NAN} spec_e;

    typedef struct packed {
        logic [15:0] p;
        logic        ovf;
        logic        unf;
        logic        inv;
    } res_t;

    // Only FTZ=1 is a supported configuration: exponent 0 is always treated as zero.
    function automatic logic is_zero(input logic [15:0] x);
        return (x[14:7] == 8'h00) && ((FTZ != 0) || (x[6:0] == 7'h00));
    endfunction

    function automatic logic is_inf(input logic [15:0] x);
        return (x[14:7] == 8'hFF) && (x[6:0] == 7'h00);
    endfunction

    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:7] == 8'hFF) && (x[6:0] != 7'h00);
    endfunction

    // Normalize the 8x8 product, round to nearest even, then saturate or flush.
    function automatic res_t norm_round(input logic             sign,
                                        input logic signed [9:0] e,
                                        input logic [15:0]       prod);
        res_t             r;
        logic signed [9:0] en;
        logic [6:0]       frac;
        logic             g;
        logic             s;
        logic [7:0]       fr;
        r = '0;
        if (prod[15]) begin
            frac = prod[14:8];
            g    = prod[7];
            s    = |prod[6:0];
            en   = e + 10'sd1;
        end else begin
            frac = prod[13:7];
            g    = prod[6];
            s    = |prod[5:0];
            en   = e;
        end
        fr = {1'b0, frac} + {7'd0, g & (s | frac[0])};
        if (fr[7]) begin
            en = en + 10'sd1;
        end
        if (en >= 10'sd255) begin
            r.p   = {sign, 8'hFF, 7'h00};
            r.ovf = 1'b1;
        end else if (en <= 10'sd0) begin
            r.p   = {sign, 15'h0000};
            r.unf = 1'b1;
        end else begin
            r.p = {sign, en[7:0], fr[6:0]};
        end
        return r;
    endfunction

    logic stall;
    logic advance;
    logic accept;

    logic rdy_q, rdy_d;
    logic vld_p1_q, vld_p1_d;
    logic vld_p2_q, vld_p2_d;
    logic vld_p3_q, vld_p3_d;

    logic              sign_p1_q, sign_p1_d;
    logic signed [9:0] exp_p1_q, exp_p1_d;
    logic [7:0]        man_a_p1_q, man_a_p1_d;
    logic [7:0]        man_b_p1_q, man_b_p1_d;
    spec_e             spec_p1_q, spec_p1_d;

    logic              sign_p2_q, sign_p2_d;
    logic signed [9:0] exp_p2_q, exp_p2_d;
    logic [15:0]       prod_p2_q, prod_p2_d;
    spec_e             spec_p2_q, spec_p2_d;

    res_t res_p3_q, res_p3_d;
    res_t res_norm;

    logic za, zb, ia, ib, na, nb;

    always_comb begin
        stall    = vld_p3_q & ~out_ready;
        advance  = ~stall;
        in_ready = rdy_q & advance;
        accept   = in_valid & in_ready;
        rdy_d    = 1'b1;
        vld_p1_d = advance ? accept   : vld_p1_q;
        vld_p2_d = advance ? vld_p1_q : vld_p2_q;
        vld_p3_d = advance ? vld_p2_q : vld_p3_q;
    end

    // Stage 1: classify operands, sign, biased exponent sum, mantissas with hidden bit
    always_comb begin
        za = is_zero(a);
        zb = is_zero(b);
        ia = is_inf(a);
        ib = is_inf(b);
        na = is_nan(a);
        nb = is_nan(b);
        sign_p1_d  = sign_p1_q;
        exp_p1_d   = exp_p1_q;
        man_a_p1_d = man_a_p1_q;
        man_b_p1_d = man_b_p1_q;
        spec_p1_d  = spec_p1_q;
        if (advance && accept) begin
            sign_p1_d  = a[15] ^ b[15];
            exp_p1_d   = $signed({2'b00, a[14:7]}) + $signed({2'b00, b[14:7]}) - 10'sd127;
            man_a_p1_d = {1'b1, a[6:0]};
            man_b_p1_d = {1'b1, b[6:0]};
            if (na || nb || (ia && zb) || (za && ib)) begin
                spec_p1_d = SP_NAN;
            end else if (ia || ib) begin
                spec_p1_d = SP_INF;
            end else if (za || zb) begin
                spec_p1_d = SP_ZERO;
            end else begin
                spec_p1_d = SP_NONE;
            end
        end
    end

    // Stage 2: mantissa multiply, special-case code rides along
    always_comb begin
        sign_p2_d = sign_p2_q;
        exp_p2_d  = exp_p2_q;
        prod_p2_d = prod_p2_q;
        spec_p2_d = spec_p2_q;
        if (advance && vld_p1_q) begin
            sign_p2_d = sign_p1_q;
            exp_p2_d  = exp_p1_q;
            prod_p2_d = man_a_p1_q * man_b_p1_q;
            spec_p2_d = spec_p1_q;
        end
    end

    // Stage 3: normalize/round/pack, specials override the arithmetic result
    always_comb begin
        res_norm = norm_round(sign_p2_q, exp_p2_q, prod_p2_q);
        res_p3_d = res_p3_q;
        if (advance && vld_p2_q) begin
            unique case (spec_p2_q)
                SP_NAN:  res_p3_d = '{p: QNAN, ovf: 1'b0, unf: 1'b0, inv: 1'b1};
                SP_INF:  res_p3_d = '{p: {sign_p2_q, 8'hFF, 7'h00}, ovf: 1'b0, unf: 1'b0, inv: 1'b0};
                SP_ZERO: res_p3_d = '{p: {sign_p2_q, 15'h0000}, ovf: 1'b0, unf: 1'b0, inv: 1'b0};
                default: res_p3_d = res_norm;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q    <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            res_p3_q <= '0;
        end else begin
            rdy_q    <= rdy_d;
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
            res_p3_q <= res_p3_d;
        end
    end

    always_ff @(posedge clk) begin
        sign_p1_q  <= sign_p1_d;
        exp_p1_q   <= exp_p1_d;
        man_a_p1_q <= man_a_p1_d;
        man_b_p1_q <= man_b_p1_d;
        spec_p1_q  <= spec_p1_d;
        sign_p2_q  <= sign_p2_d;
        exp_p2_q   <= exp_p2_d;
        prod_p2_q  <= prod_p2_d;
        spec_p2_q  <= spec_p2_d;
    end

    assign out_valid = vld_p3_q;
    assign p         = res_p3_q.p;
    assign ovf       = res_p3_q.ovf;
    assign unf       = res_p3_q.unf;
    assign inv       = res_p3_q.inv;

endmodule
